// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types and constants for the 7-segment scan scheduler
// Contents: scan FSM state encoding, hex-to-segment lookup table, shift word width.
package seg_scan_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_ISSUE       = 3'd1,
      S_WAIT_ACK    = 3'd2,
      S_WAIT_DONE   = 3'd3,
      S_DWELL       = 3'd4,
      S_BLANK_ISSUE = 3'd5,
      S_BLANK_WAIT  = 3'd6
   } scan_state_t;

   // Active-high {g,f,e,d,c,b,a} codes; element [0] is the last entry listed.
   localparam logic [15:0][6:0] HEX7_TAB = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg_scan_scheduler_hex7_decode.sv
// rtl/seg_scan_scheduler_hex7_decode.sv - combinational hex nibble to 7-segment decoder
// Ports: nibble (4-bit value in), seg (active-high {g,f,e,d,c,b,a} out).
module hex7_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX7_TAB[nibble];

endmodule

// File: rtl/seg_scan_scheduler.sv
// rtl/seg_scan_scheduler.sv - time-multiplexed scan controller for a 74HC595 7-segment chain
// Ports: clk, rst_n (async, active-low); enable, digits, dp, blank, upd from the application;
//        sh_start/sh_data out and sh_busy in for the shift engine handshake;
//        cur_digit, frame_tick, err (sticky ack timeout) status outputs.
module seg_scan_scheduler
   import seg_scan_pkg::*;
#(
   parameter int NDIG           = 4,
   parameter int DWELL          = 100000,
   parameter int ACK_TIMEOUT    = 8,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [4*NDIG-1:0]   digits,
   input  logic [NDIG-1:0]     dp,
   input  logic [NDIG-1:0]     blank,
   input  logic                upd,
   output logic                sh_start,
   output logic [WORD_W-1:0]   sh_data,
   input  logic                sh_busy,
   output logic [2:0]          cur_digit,
   output logic                frame_tick,
   output logic                err
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [DW_W-1:0]   DW_LOAD    = DW_W'(DWELL - 1);
   localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [2:0]        LAST_DIG   = 3'(NDIG - 1);
   localparam logic [7:0]        SEG_POL    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [7:0]        DIG_POL    = (DIG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [7:0]        DIG_MASK   = 8'((9'd1 << NDIG) - 9'd1);
   localparam logic [WORD_W-1:0] BLANK_WORD = {SEG_POL, DIG_POL};

   scan_state_t          state;
   logic                 pending;
   logic [4*NDIG-1:0]    shd_digits;
   logic [NDIG-1:0]      shd_dp;
   logic [NDIG-1:0]      shd_blank;
   logic [DW_W-1:0]      dw_cnt;
   logic [TO_W-1:0]      to_cnt;
   logic                 busy_seen;

   logic [2:0]           issue_digit;
   logic                 load_shadow;
   logic [4*NDIG-1:0]    src_digits;
   logic [NDIG-1:0]      src_dp;
   logic [NDIG-1:0]      src_blank;
   logic [3:0]           nibble;
   logic                 dp_bit;
   logic                 blank_bit;
   logic [6:0]           seg7;
   logic [7:0]           seg_raw;
   logic [7:0]           sel_raw;
   logic [WORD_W-1:0]    issue_word;

   hex7_decode u_hex7 (
      .nibble (nibble),
      .seg    (seg7)
   );

   // The word is built for the digit about to be issued, so it is ready on the
   // same edge that raises sh_start. A digit-0 issue with an update requested
   // uses the live inputs directly, since the shadow copy lands on that edge.
   always_comb begin
      issue_digit = 3'd0;
      if (state == S_DWELL && cur_digit != LAST_DIG) begin
         issue_digit = cur_digit + 3'd1;
      end
      load_shadow = (issue_digit == 3'd0) && (pending || upd);
      src_digits  = load_shadow ? digits : shd_digits;
      src_dp      = load_shadow ? dp     : shd_dp;
      src_blank   = load_shadow ? blank  : shd_blank;
      nibble      = 4'd0;
      dp_bit      = 1'b0;
      blank_bit   = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (issue_digit == 3'(i)) begin
            nibble    = src_digits[4*i +: 4];
            dp_bit    = src_dp[i];
            blank_bit = src_blank[i];
         end
      end
      seg_raw    = blank_bit ? 8'h00 : {dp_bit, seg7};
      sel_raw    = (8'd1 << issue_digit) & DIG_MASK;
      issue_word = {seg_raw ^ SEG_POL, sel_raw ^ DIG_POL};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         sh_start   <= 1'b0;
         sh_data    <= BLANK_WORD;
         cur_digit  <= 3'd0;
         frame_tick <= 1'b0;
         err        <= 1'b0;
         pending    <= 1'b0;
         shd_digits <= '0;
         shd_dp     <= '0;
         shd_blank  <= '0;
         dw_cnt     <= '0;
         to_cnt     <= '0;
         busy_seen  <= 1'b0;
      end else begin
         sh_start   <= 1'b0;
         frame_tick <= 1'b0;
         if (upd) begin
            pending <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (enable) begin
                  cur_digit <= issue_digit;
                  sh_data   <= issue_word;
                  sh_start  <= 1'b1;
                  state     <= S_ISSUE;
                  if (load_shadow) begin
                     shd_digits <= digits;
                     shd_dp     <= dp;
                     shd_blank  <= blank;
                     pending    <= 1'b0;
                  end
               end
            end

            // sh_start is high for exactly this one cycle.
            S_ISSUE: begin
               to_cnt <= '0;
               state  <= S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
               if (sh_busy) begin
                  state <= S_WAIT_DONE;
               end else if (to_cnt == TO_LAST) begin
                  err    <= 1'b1;
                  dw_cnt <= DW_LOAD;
                  state  <= S_DWELL;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            S_WAIT_DONE: begin
               if (!sh_busy) begin
                  dw_cnt <= DW_LOAD;
                  state  <= S_DWELL;
               end
            end

            S_DWELL: begin
               if (dw_cnt == '0) begin
                  cur_digit <= issue_digit;
                  if (cur_digit == LAST_DIG) begin
                     frame_tick <= 1'b1;
                  end
                  if (enable) begin
                     sh_data  <= issue_word;
                     sh_start <= 1'b1;
                     state    <= S_ISSUE;
                     if (load_shadow) begin
                        shd_digits <= digits;
                        shd_dp     <= dp;
                        shd_blank  <= blank;
                        pending    <= 1'b0;
                     end
                  end else begin
                     sh_data  <= BLANK_WORD;
                     sh_start <= 1'b1;
                     state    <= S_BLANK_ISSUE;
                  end
               end else begin
                  dw_cnt <= dw_cnt - 1'b1;
               end
            end

            S_BLANK_ISSUE: begin
               to_cnt    <= '0;
               busy_seen <= 1'b0;
               state     <= S_BLANK_WAIT;
            end

            // First phase waits for busy to rise (with timeout), second for it to fall.
            S_BLANK_WAIT: begin
               if (!busy_seen) begin
                  if (sh_busy) begin
                     busy_seen <= 1'b1;
                  end else if (to_cnt == TO_LAST) begin
                     err   <= 1'b1;
                     state <= S_IDLE;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end else if (!sh_busy) begin
                  state <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb/tb_seg_scan_scheduler.sv - self-checking bench for seg_scan_scheduler
module tb_seg_scan_scheduler;

   localparam int NDIG = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        upd;
   logic        sh_start;
   logic [15:0] sh_data;
   logic        sh_busy;
   logic [2:0]  cur_digit;
   logic        frame_tick;
   logic        err;

   logic        def_start;
   logic [15:0] def_data;
   logic [2:0]  def_digit;
   logic        def_tick;
   logic        def_err;

   logic        no_ack;
   int          eng_t;
   int          errors = 0;
   int          checks = 0;
   int          ftick  = 0;

   logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [15:0] exp_a [4] = '{16'h6601, 16'h4F02, 16'h5B04, 16'h0608};
   logic [15:0] exp_b [4] = '{16'hE601, 16'h4F02, 16'h0004, 16'h0608};
   logic [15:0] exp_c [4] = '{16'h5E01, 16'h3902, 16'h7C04, 16'h7708};

   always #5 clk = ~clk;

   seg_scan_scheduler #(
      .NDIG(NDIG), .DWELL(4), .ACK_TIMEOUT(8), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits), .dp(dp), .blank(blank),
      .upd(upd), .sh_start(sh_start), .sh_data(sh_data), .sh_busy(sh_busy),
      .cur_digit(cur_digit), .frame_tick(frame_tick), .err(err)
   );

   seg_scan_scheduler dut_def (
      .clk(clk), .rst_n(rst_n), .enable(1'b0), .digits(16'h0000), .dp(4'h0), .blank(4'h0),
      .upd(1'b0), .sh_start(def_start), .sh_data(def_data), .sh_busy(1'b0),
      .cur_digit(def_digit), .frame_tick(def_tick), .err(def_err)
   );

   // Shift engine model: busy rises 2 cycles after start and lasts 20 cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) eng_t <= 0;
      else if (sh_start && !no_ack) eng_t <= 1;
      else if (eng_t != 0 && eng_t < 22) eng_t <= eng_t + 1;
      else eng_t <= 0;
   end
   assign sh_busy = (eng_t >= 2) && (eng_t < 22);

   always @(negedge clk) if (frame_tick === 1'b1) ftick++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start(output logic [15:0] w, output logic [2:0] d);
      int n;
      n = 0;
      @(negedge clk);
      while (sh_start !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sh_start !== 1'b1) begin
         checks++;
         errors++;
         $error("FAIL start_timeout observed=no sh_start expected=sh_start within 400 cycles");
      end
      w = sh_data;
      d = cur_digit;
   endtask

   task automatic wait_busy(input logic level, input string tag);
      int n;
      n = 0;
      while (sh_busy !== level && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(sh_busy), 32'(level));
   endtask

   task automatic pulse_upd();
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
   endtask

   function automatic logic [15:0] model_word(input logic [15:0] dg, input logic [3:0] dpv,
                                              input logic [3:0] bl, input int i);
      logic [3:0] nib;
      logic [7:0] seg;
      nib = dg[4*i +: 4];
      seg = bl[i] ? 8'h00 : {dpv[i], seg_tab[nib]};
      return {seg, 8'(1 << i)};
   endfunction

   initial begin
      logic [15:0] w;
      logic [2:0]  d;
      logic [15:0] m_dg;
      logic [3:0]  m_dp;
      logic [3:0]  m_bl;
      logic        m_pend;
      int          pos;
      int          starts;

      rst_n = 1'b0; enable = 1'b0; digits = '0; dp = '0; blank = '0; upd = 1'b0; no_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sh_start", 32'(sh_start), 0);
      chk("rst_sh_data", 32'(sh_data), 32'h0000);
      chk("rst_cur_digit", 32'(cur_digit), 0);
      chk("rst_frame_tick", 32'(frame_tick), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_default_sh_data", 32'(def_data), 32'hFF00);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_start", 32'(sh_start), 0);

      // Frame A: enable and upd together; start must follow one cycle later.
      digits = 16'h1234; enable = 1'b1; upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      chk("a_start_latency", 32'(sh_start), 1);
      chk("a_word0", 32'(sh_data), 32'(exp_a[0]));
      chk("a_digit0", 32'(cur_digit), 0);
      @(negedge clk);
      chk("a_start_one_cycle", 32'(sh_start), 0);
      chk("a_data_stable", 32'(sh_data), 32'(exp_a[0]));
      for (int i = 1; i < 4; i++) begin
         wait_start(w, d);
         chk("a_word", 32'(w), 32'(exp_a[i]));
         chk("a_digit", 32'(d), 32'(i));
      end
      chk("a_no_tick_yet", 32'(ftick), 0);
      dp = 4'b0001; blank = 4'b0100;
      pulse_upd();

      // Frame B: dp/blank take effect; digits change at digit 1 must not tear the frame.
      for (int i = 0; i < 4; i++) begin
         wait_start(w, d);
         chk("b_word", 32'(w), 32'(exp_b[i]));
         chk("b_digit", 32'(d), 32'(i));
         if (i == 1) begin
            chk("b_frame_tick_once", 32'(ftick), 1);
            digits = 16'hABCD; dp = 4'b0000; blank = 4'b0000;
            pulse_upd();
         end
      end

      // Frame C: new values from the start.
      for (int i = 0; i < 4; i++) begin
         wait_start(w, d);
         chk("c_word", 32'(w), 32'(exp_c[i]));
         chk("c_digit", 32'(d), 32'(i));
      end
      chk("c_frame_ticks", 32'(ftick), 2);

      // Randomized frames against the reference model.
      m_dg = 16'hABCD; m_dp = 4'h0; m_bl = 4'h0; m_pend = 1'b0;
      for (int f = 0; f < 3; f++) begin
         pos = $urandom_range(0, 3);
         for (int i = 0; i < 4; i++) begin
            wait_start(w, d);
            if (d == 3'd0 && m_pend) begin
               m_dg = digits; m_dp = dp; m_bl = blank; m_pend = 1'b0;
            end
            chk("rnd_digit", 32'(d), 32'(i));
            chk("rnd_word", 32'(w), 32'(model_word(m_dg, m_dp, m_bl, i)));
            if (i == pos) begin
               digits = 16'($urandom);
               dp     = 4'($urandom);
               blank  = 4'($urandom);
               if (f == 2 || $urandom_range(0, 1) == 1) begin
                  pulse_upd();
                  m_pend = 1'b1;
               end
            end
         end
      end

      // Enable dropped during digit 2 transfer: digit completes, then blank word, then idle.
      for (int k = 0; k < 8; k++) begin
         wait_start(w, d);
         if (d == 3'd0 && m_pend) begin
            m_dg = digits; m_dp = dp; m_bl = blank; m_pend = 1'b0;
         end
         if (d == 3'd2) break;
      end
      chk("stop_digit2", 32'(d), 2);
      chk("stop_word2", 32'(w), 32'(model_word(m_dg, m_dp, m_bl, 2)));
      repeat (5) @(negedge clk);
      enable = 1'b0;
      wait_start(w, d);
      chk("blank_word", 32'(w), 32'h0000);
      chk("blank_digit", 32'(d), 3);
      @(negedge clk);
      wait_busy(1'b1, "blank_busy_rise");
      wait_busy(1'b0, "blank_busy_fall");
      starts = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (sh_start === 1'b1) starts++;
      end
      chk("idle_no_more_starts", 32'(starts), 0);
      chk("idle_data_blank", 32'(sh_data), 32'h0000);
      chk("idle_no_err", 32'(err), 0);

      // Engine never answers: err after 8 cycles, scanning moves on.
      no_ack = 1'b1; enable = 1'b1;
      wait_start(w, d);
      if (m_pend) begin
         m_dg = digits; m_dp = dp; m_bl = blank; m_pend = 1'b0;
      end
      chk("noack_digit0", 32'(d), 0);
      chk("noack_word0", 32'(w), 32'(model_word(m_dg, m_dp, m_bl, 0)));
      repeat (8) @(negedge clk);
      chk("err_before_timeout", 32'(err), 0);
      @(negedge clk);
      chk("err_after_timeout", 32'(err), 1);
      wait_start(w, d);
      chk("noack_next_digit", 32'(d), 1);
      chk("noack_word1", 32'(w), 32'(model_word(m_dg, m_dp, m_bl, 1)));
      @(negedge clk);
      no_ack = 1'b0;

      // Reset in the middle of a transfer.
      wait_start(w, d);
      chk("pre_reset_digit", 32'(d), 2);
      @(negedge clk);
      wait_busy(1'b1, "pre_reset_busy");
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sh_start", 32'(sh_start), 0);
      chk("mid_rst_sh_data", 32'(sh_data), 32'h0000);
      chk("mid_rst_cur_digit", 32'(cur_digit), 0);
      chk("mid_rst_frame_tick", 32'(frame_tick), 0);
      chk("mid_rst_err", 32'(err), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_start(w, d);
      chk("restart_digit", 32'(d), 0);
      chk("restart_word", 32'(w), 32'h3F01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
